hazard_scoreboard: RTL and testbench

- Parametrised stall/flush controller for the pipelined MIPS core. Replaces fixed load-use detection with a per-register scoreboard that tracks variable result latency (ALU, load, multi-cycle multiply).
- Sits between the control unit/decode stage and the pipeline registers.
- Drives StallF, StallD, FlushD and FlushE.
- Operand forwarding selection stays in the existing forwarding logic. This block only guarantees that a forwardable value exists when an instruction enters Execute.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_scoreboard_sb_entry.sv | 28 ++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
//   NREG_DEF / LAT_W_DEF : default register count and latency-field width
//   LAT_ALU / LAT_LOAD / LAT_MUL : typical result latencies seen by decode
//   eff_lat()            : latency 0 is treated as 1
package hazard_pkg;

   localparam int unsigned NREG_DEF  = 32;
   localparam int unsigned LAT_W_DEF = 3;

   localparam int unsigned LAT_ALU  = 1;
   localparam int unsigned LAT_LOAD = 2;
   localparam int unsigned LAT_MUL  = 4;

   function automatic int unsigned eff_lat(input int unsigned lat);
      return (lat == 0) ? 1 : lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: one scoreboard countdown register.
// Ports:
//   clk, rst  : clock, synchronous active-high clear
//   load      : load load_val this cycle (takes priority over decrement)
//   load_val  : cycles until the result becomes forwardable
//   cnt       : current countdown, decrements toward 0 while nonzero
module sb_entry
   import hazard_pkg::*;
#(
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard stall/flush controller.
// Tracks outstanding result latency per architectural register and stalls
// Decode until every used operand is forwardable (or, for a branch resolved
// in Decode, fully written back) and no write-after-write ordering is broken.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   IssueD          : valid instruction in Decode
//   RsD/RtD, UsesRsD/UsesRtD : source operands and their use flags
//   BranchD         : operands needed in Decode (branch compare)
//   JumpD           : jump in Decode (only acts through PCSrcTakenD)
//   PCSrcTakenD     : redirect this cycle
//   RegWriteD/DestD/LatencyD : destination write and its latency
//   StallF/StallD/FlushD/FlushE : pipeline control
//   BusyMask        : per-register pending flags
//   StallCount/FlushCount : saturating event counters, present only when
//                    HAZARD_SB_STATS_EN is defined
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG   = NREG_DEF,
   parameter int unsigned REG_AW = $clog2(NREG),
   parameter int unsigned LAT_W  = LAT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IssueD,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic              UsesRsD,
   input  logic              UsesRtD,
   input  logic              BranchD,
   input  logic              JumpD,
   input  logic              PCSrcTakenD,
   input  logic              RegWriteD,
   input  logic [REG_AW-1:0] DestD,
   input  logic [LAT_W-1:0]  LatencyD,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [NREG-1:0]   BusyMask
`ifdef HAZARD_SB_STATS_EN
   ,
   output logic [31:0]       StallCount,
   output logic [31:0]       FlushCount
`endif
);

   logic [LAT_W-1:0] cnt [NREG];
   logic [LAT_W-1:0] lat_eff;
   logic             rs_ready;
   logic             rt_ready;
   logic             waw;
   logic             hazard;
   logic             accept;
   logic             redirect;

   assign cnt[0]  = '0;
   assign lat_eff = LAT_W'(eff_lat(32'(LatencyD)));

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
         .clk      (CLK),
         .rst      (RST),
         .load     (accept && (DestD == REG_AW'(r))),
         .load_val (lat_eff),
         .cnt      (cnt[r])
      );
   end

   // A jump is already folded into PCSrcTakenD; this term is redundant.
   assign redirect = PCSrcTakenD | (JumpD & PCSrcTakenD);

   always_comb begin
      rs_ready = 1'b1;
      rt_ready = 1'b1;
      // Branch operands are compared in Decode, so the value must already be
      // written (cnt==0); Execute consumers can take it from the bypass (<=1).
      if (UsesRsD)
         rs_ready = BranchD ? (cnt[RsD] == '0) : (cnt[RsD] <= LAT_W'(1));
      if (UsesRtD)
         rt_ready = BranchD ? (cnt[RtD] == '0) : (cnt[RtD] <= LAT_W'(1));
      waw    = RegWriteD && (DestD != '0) && (cnt[DestD] > lat_eff);
      hazard = IssueD && (!rs_ready || !rt_ready || waw);
      accept = IssueD && !hazard && RegWriteD && (DestD != '0);
   end

   always_comb begin
      StallF = hazard;
      StallD = hazard;
      FlushE = hazard;
      // A stalled branch has not resolved yet, so it must not flush.
      FlushD = IssueD && redirect && !hazard;
   end

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++)
         BusyMask[r] = (cnt[r] != '0);
   end

`ifdef HAZARD_SB_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (hazard && (StallCount != '1))
            StallCount <= StallCount + 32'd1;
         if (FlushD && (FlushCount != '1))
            FlushCount <= FlushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a cycle-timestamp reference model.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int LAT_W = 3;

   logic CLK = 1'b0;
   logic RST;
   logic IssueD, UsesRsD, UsesRtD, BranchD, JumpD, PCSrcTakenD, RegWriteD;
   logic [AW-1:0] RsD, RtD, DestD;
   logic [LAT_W-1:0] LatencyD;
   logic StallF, StallD, FlushD, FlushE;
   logic [NREG-1:0] BusyMask;
`ifdef HAZARD_SB_STATS_EN
   logic [31:0] StallCount, FlushCount;
   longint m_stalls, m_flushes;
`endif

   hazard_scoreboard #(.NREG(NREG), .LAT_W(LAT_W)) dut (
      .CLK(CLK), .RST(RST), .IssueD(IssueD), .RsD(RsD), .RtD(RtD),
      .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .BranchD(BranchD), .JumpD(JumpD),
      .PCSrcTakenD(PCSrcTakenD), .RegWriteD(RegWriteD), .DestD(DestD),
      .LatencyD(LatencyD), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .FlushE(FlushE), .BusyMask(BusyMask)
`ifdef HAZARD_SB_STATS_EN
      , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: each register records the cycle at which its result is fully
   // written; remaining latency is that timestamp minus the current cycle.
   longint avail [NREG];
   longint cyc = 0;

   function automatic longint rem(input int r);
      return (avail[r] > cyc) ? avail[r] - cyc : 0;
   endfunction

   initial for (int r = 0; r < NREG; r++) avail[r] = 0;

   always @(negedge CLK) begin
      longint e;
      bit ok_a, ok_b, waw, hz, fd;
      logic [NREG-1:0] bm;
      e    = (LatencyD == 0) ? 1 : longint'(LatencyD);
      ok_a = !UsesRsD || (BranchD ? rem(int'(RsD)) == 0 : rem(int'(RsD)) <= 1);
      ok_b = !UsesRtD || (BranchD ? rem(int'(RtD)) == 0 : rem(int'(RtD)) <= 1);
      waw  = RegWriteD && DestD != 0 && rem(int'(DestD)) > e;
      hz   = IssueD && (!ok_a || !ok_b || waw);
      fd   = IssueD && PCSrcTakenD && !hz;
      for (int r = 0; r < NREG; r++) bm[r] = rem(r) > 0;
      chk("stallf", 64'(StallF), 64'(hz));
      chk("stalld", 64'(StallD), 64'(hz));
      chk("flushe", 64'(FlushE), 64'(hz));
      chk("flushd", 64'(FlushD), 64'(fd));
      chk("busymask", 64'(BusyMask), 64'(bm));
`ifdef HAZARD_SB_STATS_EN
      chk("stallcount", 64'(StallCount), 64'(m_stalls));
      chk("flushcount", 64'(FlushCount), 64'(m_flushes));
      if (RST) begin
         m_stalls = 0; m_flushes = 0;
      end else begin
         if (hz) m_stalls++;
         if (fd) m_flushes++;
      end
`endif
      if (RST) begin
         for (int r = 0; r < NREG; r++) avail[r] = 0;
      end else if (IssueD && !hz && RegWriteD && DestD != 0) begin
         avail[DestD] = cyc + 1 + e;
      end
      cyc++;
   end

   task automatic drive(input logic iss, input int rs, input int rt,
                        input logic urs, input logic urt, input logic br,
                        input logic pcs, input logic rw, input int dest,
                        input int lat);
      @(posedge CLK); #1;
      RST = 1'b0;
      IssueD = iss; RsD = AW'(rs); RtD = AW'(rt);
      UsesRsD = urs; UsesRtD = urt; BranchD = br; JumpD = 1'b0;
      PCSrcTakenD = pcs; RegWriteD = rw; DestD = AW'(dest);
      LatencyD = LAT_W'(lat);
      #5;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   int n;

   initial begin
`ifdef HAZARD_SB_STATS_EN
      m_stalls = 0; m_flushes = 0;
`endif
      RST = 1'b1;
      IssueD = 0; RsD = '0; RtD = '0; UsesRsD = 0; UsesRtD = 0; BranchD = 0;
      JumpD = 0; PCSrcTakenD = 0; RegWriteD = 0; DestD = '0; LatencyD = '0;
      repeat (2) @(posedge CLK);
      idle();
      chk("rst_busy", 64'(BusyMask), 64'd0);
      chk("rst_stall", 64'(StallD), 64'd0);

      // load-use
      drive(1, 1, 0, 1, 0, 0, 0, 1, 8, LAT_LOAD);
      chk("lu_issue_stall", 64'(StallD), 64'd0);
      drive(1, 8, 0, 1, 0, 0, 0, 1, 10, LAT_ALU);
      chk("lu_stall", 64'(StallD), 64'd1);
      chk("lu_flushe", 64'(FlushE), 64'd1);
      chk("lu_busy8", 64'(BusyMask[8]), 64'd1);
      drive(1, 8, 0, 1, 0, 0, 0, 1, 10, LAT_ALU);
      chk("lu_go", 64'(StallD), 64'd0);
      idle();
      chk("lu_busy8_done", 64'(BusyMask[8]), 64'd0);

      // ALU back-to-back
      idle();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 5, LAT_ALU);
      drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("alu_nostall", 64'(StallD), 64'd0);
      chk("alu_busy5", 64'(BusyMask[5]), 64'd1);
      idle();
      chk("alu_busy5_clr", 64'(BusyMask[5]), 64'd0);

      // latency 0 behaves as 1
      drive(1, 0, 0, 0, 0, 0, 0, 1, 6, 0);
      idle();
      chk("lat0_busy6", 64'(BusyMask[6]), 64'd1);
      idle();
      chk("lat0_busy6_clr", 64'(BusyMask[6]), 64'd0);

      // multiply then dependent consumer
      drive(1, 0, 0, 0, 0, 0, 0, 1, 9, LAT_MUL);
      drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("mul_rt_unused", 64'(StallD), 64'd0);
      repeat (4) idle();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 9, LAT_MUL);
      drive(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
      n = 0;
      for (int i = 0; i < 10 && StallD === 1'b1; i++) begin
         n++;
         drive(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
      end
      chk("mul_stalls", 64'(n), 64'd3);
      repeat (2) idle();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 9, LAT_MUL);
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("mul_indep", 64'(StallD), 64'd0);
      repeat (4) idle();

      // branch operand
      drive(1, 0, 0, 0, 0, 0, 0, 1, 4, LAT_ALU);
      drive(1, 4, 0, 1, 0, 1, 1, 0, 0, 0);
      chk("br_stall", 64'(StallD), 64'd1);
      chk("br_noflush", 64'(FlushD), 64'd0);
      drive(1, 4, 0, 1, 0, 1, 1, 0, 0, 0);
      chk("br_go", 64'(StallD), 64'd0);
      chk("br_flush", 64'(FlushD), 64'd1);

      // WAW
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7, LAT_MUL);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7, LAT_ALU);
      n = 0;
      for (int i = 0; i < 10 && StallD === 1'b1; i++) begin
         n++;
         drive(1, 0, 0, 0, 0, 0, 0, 1, 7, LAT_ALU);
      end
      chk("waw_stalls", 64'(n), 64'd3);
      repeat (3) idle();

      // R0 never busy
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, LAT_LOAD);
      drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      chk("r0_busy", 64'(BusyMask), 64'd0);
      chk("r0_nostall", 64'(StallD), 64'd0);

      // reset mid-flight
      drive(1, 0, 0, 0, 0, 0, 0, 1, 9, 7);
      idle();
      chk("rst_pre_busy9", 64'(BusyMask[9]), 64'd1);
      @(posedge CLK); #1;
      RST = 1'b1; IssueD = 0;
      #5;
      drive(1, 9, 9, 1, 1, 0, 0, 0, 0, 0);
      chk("rst_busy_clr", 64'(BusyMask), 64'd0);
      chk("rst_nostall", 64'(StallD), 64'd0);
`ifdef HAZARD_SB_STATS_EN
      chk("rst_stallcount", 64'(StallCount), 64'd0);
`endif
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
